noc_input_fifo: RTL and testbench

- Flit buffer sitting directly upstream of the router output flow-control stage.
- Accepts flits from the link or crossbar with a val/ret handshake and stores them in a circular FIFO.
- Presents the head flit together with the `empty` status to the output flow-control stage.
- Pops one flit per cycle when that stage asserts `read`.

---
 rtl/noc_input_fifo.sv | 96 +++++++++
 tb/tb_noc_input_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/noc_input_fifo.sv
// rtl/noc_input_fifo.sv - flit input FIFO with val/ret upstream handshake and FWFT head
//
// Purpose: circular flit buffer ahead of the router output flow-control stage.
//   Upstream writes with val_in when ret_out is high; the downstream stage sees
//   the head flit on data_out with empty, and pops with read.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   data_in, val_in     incoming flit and its valid
//   ret_out             high when a flit can be accepted (== ~full)
//   data_out            head flit, first-word-fall-through
//   empty, full, count  occupancy status decoded from registered count
//   read                pop request from the output flow-control stage
//   err                 (only with NOC_FIFO_ERR_FLAG_EN) sticky flag for a write
//                       while full or a read while empty
// Optional feature macro: NOC_FIFO_ERR_FLAG_EN

module noc_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  val_in,
  output logic                  ret_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  input  logic                  read,
  output logic [ADDR_W:0]       count
`ifdef NOC_FIFO_ERR_FLAG_EN
  ,
  output logic                  err
`endif
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic                  wr_fire;
  logic                  rd_fire;

  // Status is decoded from registered count only, so ret_out has no
  // combinational dependence on read.
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign ret_out = ~full;

  // When full and read arrive together only the read fires; when empty and
  // val_in arrive together only the write fires.
  assign wr_fire = val_in & ~full;
  assign rd_fire = read & ~empty;

  assign data_out = mem[rd_ptr];

  // Storage is deliberately not reset; control never looks at its contents.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_fire && !rd_fire) begin
        count <= count + 1'b1;
      end else if (rd_fire && !wr_fire) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef NOC_FIFO_ERR_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((val_in && full) || (read && empty)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_input_fifo.sv
// tb/tb_noc_input_fifo.sv - scoreboard testbench for noc_input_fifo

module tb_noc_input_fifo;

  localparam int DW = 32;
  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          val_in;
  logic          ret_out;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;
  logic          read;
  logic [AW:0]   count;
`ifdef NOC_FIFO_ERR_FLAG_EN
  logic          err;
`endif

  int n_cmp;
  int n_bad;
  logic [DW-1:0] exp_q[$];

  noc_input_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .val_in   (val_in),
    .ret_out  (ret_out),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .read     (read),
    .count    (count)
`ifdef NOC_FIFO_ERR_FLAG_EN
    ,
    .err      (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever read && !empty,
  // so the head flit is compared on the falling edge before it.
  always @(negedge clk) begin
    if (rst_n && read && !empty) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got 0x%0h expected no pop", data_out);
      end else begin
        chk("pop_data", data_out, exp_q.pop_front());
      end
    end
  end

  // Apply inputs, then step past the next rising edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    val_in  = v;
    data_in = d;
    read    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input int c, input logic e,
                            input logic f, input logic rt);
    chk({tag, "_count"}, count, c);
    chk({tag, "_empty"}, empty, e);
    chk({tag, "_full"}, full, f);
    chk({tag, "_ret"}, ret_out, rt);
  endtask

  initial begin
    logic [DW-1:0] a_vec [4];
    logic [DW-1:0] b_vec [8];
    n_cmp = 0;
    n_bad = 0;
    a_vec = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    b_vec = '{32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6, 32'hB7, 32'hB8};
    rst_n = 1'b0;
    val_in = 1'b0;
    read = 1'b0;
    data_in = '0;

    // Reset then idle
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_status("reset", 0, 1'b1, 1'b0, 1'b1);
`ifdef NOC_FIFO_ERR_FLAG_EN
    chk("reset_err", err, 0);
`endif
    step(1'b0, 32'h0, 1'b0);
    chk_status("idle", 0, 1'b1, 1'b0, 1'b1);

    // Fill with A1..A4
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(a_vec[i]);
      step(1'b1, a_vec[i], 1'b0);
      chk("fill_count", count, i + 1);
      if (i == 0) chk("fill_head", data_out, 32'hA1);
    end
    chk_status("full", 4, 1'b0, 1'b1, 1'b0);

    // Write attempt while full, with a read: only the read fires
    step(1'b1, 32'hFF, 1'b1);
    chk_status("full_rw", 3, 1'b0, 1'b0, 1'b1);
    chk("full_rw_head", data_out, 32'hA2);
`ifdef NOC_FIFO_ERR_FLAG_EN
    chk("full_rw_err", err, 1);
`endif

    // Streaming with simultaneous read/write across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b_vec[i]);
      step(1'b1, b_vec[i], 1'b1);
      chk("stream_count", count, 3);
    end
    chk("stream_head", data_out, 32'hB6);

    // Drain
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1);
    end
    chk_status("drained", 0, 1'b1, 1'b0, 1'b1);

    // Empty boundary: simultaneous read/write, only the write fires
    exp_q.push_back(32'hC5);
    step(1'b1, 32'hC5, 1'b1);
    chk_status("empty_rw", 1, 1'b0, 1'b0, 1'b1);
    chk("empty_rw_head", data_out, 32'hC5);
    step(1'b0, 32'h0, 1'b1);
    chk_status("pop_c5", 0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk_status("read_empty", 0, 1'b1, 1'b0, 1'b1);
`ifdef NOC_FIFO_ERR_FLAG_EN
    chk("read_empty_err", err, 1);
`endif

    // Async reset mid-stream at count=3
    exp_q.push_back(32'hD1);
    step(1'b1, 32'hD1, 1'b0);
    exp_q.push_back(32'hD2);
    step(1'b1, 32'hD2, 1'b0);
    exp_q.push_back(32'hD3);
    step(1'b1, 32'hD3, 1'b0);
    val_in = 1'b0;
    chk("pre_rst_count", count, 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk_status("async_rst", 0, 1'b1, 1'b0, 1'b1);
`ifdef NOC_FIFO_ERR_FLAG_EN
    chk("async_rst_err", err, 0);
`endif
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    exp_q.push_back(32'hD0);
    step(1'b1, 32'hD0, 1'b0);
    chk_status("post_rst", 1, 1'b0, 1'b0, 1'b1);
    chk("post_rst_head", data_out, 32'hD0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk_status("final", 0, 1'b1, 1'b0, 1'b1);
    chk("scoreboard_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
